// File: rtl/add16_sweep_checker.sv
// Synthesizable sweep checker for a registered adder: it issues every (A,B) pair in a
// rectangle, one per cycle, and compares each returned sum against A+B mod 2^WIDTH.
module add16_sweep_checker #(
    parameter int WIDTH = 16,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_lo,
    input  logic [WIDTH-1:0]   a_hi,
    input  logic [WIDTH-1:0]   b_lo,
    input  logic [WIDTH-1:0]   b_hi,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_en,
    input  logic [WIDTH-1:0]   add_s,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   vec_cnt,
    output logic [31:0]        err_cnt,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic [WIDTH-1:0]   first_err_s
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH:0] VEC_ONE = {{(2*WIDTH){1'b0}}, 1'b1};
    localparam logic [2*WIDTH:0] VEC_ZERO = {(2*WIDTH+1){1'b0}};
    localparam logic [31:0]      ERR_MAX = 32'hFFFF_FFFF;

    function automatic logic [WIDTH-1:0] mod_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_hi_r;
    logic [WIDTH-1:0]   b_lo_r;
    logic [WIDTH-1:0]   b_hi_r;

    // Expected-result pipeline; index LAT lines up with add_s on the compare edge.
    logic [LAT:0]       pipe_v_r;
    logic [WIDTH-1:0]   pipe_a_r [0:LAT];
    logic [WIDTH-1:0]   pipe_b_r [0:LAT];
    logic [WIDTH-1:0]   pipe_s_r [0:LAT];

    logic               start_ok_s;
    logic               empty_s;
    logic               last_s;
    logic               launch_s;
    logic [WIDTH-1:0]   launch_a_s;
    logic [WIDTH-1:0]   launch_b_s;
    logic               cmp_v_s;
    logic               mism_s;
    logic               younger_v_s;
    logic [31:0]        err_next_s;

    // Start acceptance, next-vector generation and compare decode.
    always_comb begin
        start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        empty_s     = (a_lo > a_hi) || (b_lo > b_hi);
        // Equality on the upper corner ends the sweep, so 0xFFFF bounds never wrap.
        last_s      = (add_a == a_hi_r) && (add_b == b_hi_r);
        launch_s    = 1'b0;
        launch_a_s  = add_a;
        launch_b_s  = add_b;
        if (start_ok_s) begin
            if (!empty_s) begin
                launch_s   = 1'b1;
                launch_a_s = a_lo;
                launch_b_s = b_lo;
            end else begin
                launch_s   = 1'b0;
            end
        end else if ((state_r == ST_RUN) && !last_s) begin
            launch_s = 1'b1;
            if (add_b < b_hi_r) begin
                launch_b_s = add_b + ONE_W;
            end else begin
                launch_a_s = add_a + ONE_W;
                launch_b_s = b_lo_r;
            end
        end else begin
            launch_s = 1'b0;
        end

        cmp_v_s     = pipe_v_r[LAT];
        mism_s      = cmp_v_s && (add_s != pipe_s_r[LAT]);
        younger_v_s = |pipe_v_r[LAT-1:0];

        if (start_ok_s) begin
            err_next_s = 32'd0;
        end else if (mism_s && (err_cnt != ERR_MAX)) begin
            err_next_s = err_cnt + 32'd1;
        end else begin
            err_next_s = err_cnt;
        end
    end

    // Shift the expected-result pipeline, loading a new entry on each launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r <= {(LAT+1){1'b0}};
            for (int i = 0; i <= LAT; i++) begin
                pipe_a_r[i] <= ZERO_W;
                pipe_b_r[i] <= ZERO_W;
                pipe_s_r[i] <= ZERO_W;
            end
        end else begin
            pipe_v_r[0] <= launch_s;
            pipe_a_r[0] <= launch_a_s;
            pipe_b_r[0] <= launch_b_s;
            pipe_s_r[0] <= mod_sum(launch_a_s, launch_b_s);
            for (int i = 1; i <= LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_a_r[i] <= pipe_a_r[i-1];
                pipe_b_r[i] <= pipe_b_r[i-1];
                pipe_s_r[i] <= pipe_s_r[i-1];
            end
        end
    end

    // Sweep FSM with registered status, counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_hi_r      <= ZERO_W;
            b_lo_r      <= ZERO_W;
            b_hi_r      <= ZERO_W;
            add_a       <= ZERO_W;
            add_b       <= ZERO_W;
            add_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            vec_cnt     <= VEC_ZERO;
            err_cnt     <= 32'd0;
            first_err_a <= ZERO_W;
            first_err_b <= ZERO_W;
            first_err_s <= ZERO_W;
        end else begin
            add_en  <= launch_s;
            err_cnt <= err_next_s;
            if (launch_s) begin
                add_a <= launch_a_s;
                add_b <= launch_b_s;
            end
            if (start_ok_s) begin
                a_hi_r      <= a_hi;
                b_lo_r      <= b_lo;
                b_hi_r      <= b_hi;
                vec_cnt     <= VEC_ZERO;
                first_err_a <= ZERO_W;
                first_err_b <= ZERO_W;
                first_err_s <= ZERO_W;
                if (empty_s) begin
                    state_r <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= 1'b1;
                end else begin
                    state_r <= ST_RUN;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            end else begin
                if (cmp_v_s) begin
                    vec_cnt <= vec_cnt + VEC_ONE;
                end
                if (mism_s && (err_cnt == 32'd0)) begin
                    first_err_a <= pipe_a_r[LAT];
                    first_err_b <= pipe_b_r[LAT];
                    first_err_s <= add_s;
                end
                case (state_r)
                    ST_RUN: begin
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // Only the entry being compared on this edge is left in flight.
                        if (!younger_v_s) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next_s == 32'd0);
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

endmodule
